// File: rtl/load_store_unit_pkg.sv
// rtl/load_store_unit_pkg.sv - shared types, data-segment bounds and access checks for the load/store unit
package load_store_unit_pkg;

    localparam logic [63:0] BEGINNING_DATA = 64'h0000_0000_0000_1000;
    localparam logic [63:0] END_DATA       = 64'h0000_0000_0000_1FFF;

    typedef enum logic [1:0] {
        SZ_BYTE  = 2'b00,
        SZ_HALF  = 2'b01,
        SZ_WORD  = 2'b10,
        SZ_DWORD = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_FAULT,
        ST_DONE
    } state_e;

    function automatic logic [64:0] size_bytes(size_e size);
        case (size)
            SZ_BYTE: return 65'd1;
            SZ_HALF: return 65'd2;
            SZ_WORD: return 65'd4;
            default: return 65'd8;
        endcase
    endfunction

    // The last-byte sum is 65 bits wide so an address near 2^64 cannot wrap past the range check.
    function automatic logic access_fault(logic [63:0] addr, size_e size);
        logic        misaligned;
        logic [64:0] last;
        case (size)
            SZ_HALF:  misaligned = addr[0];
            SZ_WORD:  misaligned = |addr[1:0];
            SZ_DWORD: misaligned = |addr[2:0];
            default:  misaligned = 1'b0;
        endcase
        last = {1'b0, addr} + size_bytes(size) - 65'd1;
        return misaligned || (addr < BEGINNING_DATA) || (last > {1'b0, END_DATA});
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - lane alignment bundle between the sequencer and the byte-lane logic
interface load_store_unit_if;
    import load_store_unit_pkg::*;

    size_e       size;
    logic        sign;
    logic [2:0]  offset;
    logic [63:0] store_data;
    logic [63:0] read_data;
    logic [7:0]  byte_en;
    logic [63:0] write_data;
    logic [63:0] load_data;

    modport master (
        output size, sign, offset, store_data, read_data,
        input  byte_en, write_data, load_data
    );

    modport slave (
        input  size, sign, offset, store_data, read_data,
        output byte_en, write_data, load_data
    );

endinterface

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - byte-enable mask, store lane shift and load extract/extend
module lsu_lane_align
    import load_store_unit_pkg::*;
(
    load_store_unit_if.slave lane
);

    logic [7:0]  mask;
    logic [63:0] keep;
    logic [63:0] extracted;

    always_comb begin
        mask = 8'h00;
        keep = 64'd0;
        case (lane.size)
            SZ_BYTE: begin mask = 8'h01; keep = 64'h0000_0000_0000_00FF; end
            SZ_HALF: begin mask = 8'h03; keep = 64'h0000_0000_0000_FFFF; end
            SZ_WORD: begin mask = 8'h0F; keep = 64'h0000_0000_FFFF_FFFF; end
            default: begin mask = 8'hFF; keep = 64'hFFFF_FFFF_FFFF_FFFF; end
        endcase

        lane.byte_en    = mask << lane.offset;
        lane.write_data = (lane.store_data & keep) << {lane.offset, 3'b000};
        extracted       = lane.read_data >> {lane.offset, 3'b000};

        case (lane.size)
            SZ_BYTE: lane.load_data = lane.sign ? {{56{extracted[7]}}, extracted[7:0]}
                                                : {56'd0, extracted[7:0]};
            SZ_HALF: lane.load_data = lane.sign ? {{48{extracted[15]}}, extracted[15:0]}
                                                : {48'd0, extracted[15:0]};
            SZ_WORD: lane.load_data = lane.sign ? {{32{extracted[31]}}, extracted[31:0]}
                                                : {32'd0, extracted[31:0]};
            default: lane.load_data = extracted;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - multicycle load/store sequencer in front of DATAMEMORY
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int MEM_LATENCY = 1
) (
    input  logic        iCLK,
    input  logic        iRST_n,
    input  logic        iStart,
    input  logic        iWrite,
    input  logic [1:0]  iSize,
    input  logic        iSigned,
    input  logic [63:0] iAddress,
    input  logic [63:0] iStoreData,
    output logic        oBusy,
    output logic        oDone,
    output logic        oFault,
    output logic [63:0] oLoadData,
    output logic        oMemReadEnable,
    output logic        oMemWriteEnable,
    output logic [7:0]  oMemByteEnable,
    output logic [63:0] oMemAddress,
    output logic [63:0] oMemWriteData,
    input  logic [63:0] iMemReadData
);

    localparam logic [1:0] LAT = 2'(MEM_LATENCY);

    state_e      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        write_q;
    size_e       size_q;
    logic        signed_q;
    logic [63:0] addr_q;
    logic [63:0] sdata_q;
    logic [63:0] load_q;
    logic        accept;
    logic        capture;
    logic        bus_active;

    load_store_unit_if lane ();

    assign lane.size       = size_q;
    assign lane.sign       = signed_q;
    assign lane.offset     = addr_q[2:0];
    assign lane.store_data = sdata_q;
    assign lane.read_data  = iMemReadData;

    lsu_lane_align u_lane_align (
        .lane (lane)
    );

    always_ff @(posedge iCLK) begin
        if (!iRST_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 2'd0;
            write_q  <= 1'b0;
            size_q   <= SZ_BYTE;
            signed_q <= 1'b0;
            addr_q   <= 64'd0;
            sdata_q  <= 64'd0;
            load_q   <= 64'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                write_q  <= iWrite;
                size_q   <= size_e'(iSize);
                signed_q <= iSigned;
                addr_q   <= iAddress;
                sdata_q  <= iStoreData;
            end
            if (capture) begin
                load_q <= lane.load_data;
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        accept          = 1'b0;
        capture         = 1'b0;
        oDone           = 1'b0;
        oFault          = 1'b0;
        oMemReadEnable  = 1'b0;
        oMemWriteEnable = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (iStart) begin
                    accept  = 1'b1;
                    state_d = access_fault(iAddress, size_e'(iSize)) ? ST_FAULT : ST_REQ;
                end
            end
            ST_REQ: begin
                oMemWriteEnable = write_q;
                oMemReadEnable  = !write_q;
                if (write_q) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_WAIT;
                    cnt_d   = LAT;
                end
            end
            ST_WAIT: begin
                // Memory data lines up with the last WAIT cycle, when the counter is 1.
                oMemReadEnable = 1'b1;
                cnt_d          = cnt_q - 2'd1;
                if (cnt_q == 2'd1) begin
                    capture = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_FAULT: begin
                oDone   = 1'b1;
                oFault  = 1'b1;
                state_d = ST_IDLE;
            end
            ST_DONE: begin
                oDone   = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus_active     = (state_q == ST_REQ) || (state_q == ST_WAIT);
    assign oBusy          = (state_q != ST_IDLE);
    assign oLoadData      = load_q;
    assign oMemAddress    = bus_active ? {addr_q[63:3], 3'b000} : 64'd0;
    assign oMemByteEnable = bus_active ? lane.byte_en : 8'h00;
    assign oMemWriteData  = (bus_active && write_q) ? lane.write_data : 64'd0;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit with a byte-level memory model
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    localparam int LAT       = 2;
    localparam int MEM_BYTES = 4096;
    localparam int PER       = 3 + LAT;

    typedef struct {
        int          done_cyc;
        logic        flt;
        logic [63:0] ld;
        int          we_n;
        int          re_n;
        int          we_cyc;
        logic [7:0]  be1;
        logic [63:0] wd1;
        logic [63:0] a1;
    } obs_t;

    logic        iCLK = 1'b0;
    logic        iRST_n = 1'b0;
    logic        iStart = 1'b0;
    logic        iWrite = 1'b0;
    logic [1:0]  iSize = 2'b00;
    logic        iSigned = 1'b0;
    logic [63:0] iAddress = 64'd0;
    logic [63:0] iStoreData = 64'd0;
    logic        oBusy, oDone, oFault;
    logic [63:0] oLoadData;
    logic        oMemReadEnable, oMemWriteEnable;
    logic [7:0]  oMemByteEnable;
    logic [63:0] oMemAddress, oMemWriteData;
    logic [63:0] iMemReadData;

    logic [63:0] rd_pipe [0:LAT-1];
    logic [7:0]  mem_b   [0:MEM_BYTES-1];
    logic [7:0]  shadow  [0:MEM_BYTES-1];
    logic        init_mem = 1'b0;

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [63:0] exp_ld = 64'd0;

    always #5 iCLK = ~iCLK;

    load_store_unit #(.MEM_LATENCY(LAT)) dut (
        .iCLK(iCLK), .iRST_n(iRST_n), .iStart(iStart), .iWrite(iWrite),
        .iSize(iSize), .iSigned(iSigned), .iAddress(iAddress), .iStoreData(iStoreData),
        .oBusy(oBusy), .oDone(oDone), .oFault(oFault), .oLoadData(oLoadData),
        .oMemReadEnable(oMemReadEnable), .oMemWriteEnable(oMemWriteEnable),
        .oMemByteEnable(oMemByteEnable), .oMemAddress(oMemAddress),
        .oMemWriteData(oMemWriteData), .iMemReadData(iMemReadData)
    );

    load_store_unit_if lane_tb ();
    lsu_lane_align u_unit_align (.lane(lane_tb));

    function automatic logic [7:0] init_byte(int i);
        return 8'((i * 37 + 11) ^ (i >> 5));
    endfunction

    function automatic int idx_of(logic [63:0] a);
        return int'(a - BEGINNING_DATA);
    endfunction

    function automatic logic [63:0] rd_word(logic [63:0] a);
        logic [63:0] w = 64'd0;
        if (a < BEGINNING_DATA || a > END_DATA) return 64'd0;
        for (int k = 0; k < 8; k++) w[8*k +: 8] = mem_b[idx_of(a) + k];
        return w;
    endfunction

    // DATAMEMORY stand-in: byte-enabled writes, reads delivered LAT cycles after the request cycle.
    always @(posedge iCLK) begin
        if (init_mem) begin
            for (int i = 0; i < MEM_BYTES; i++) mem_b[i] <= init_byte(i);
        end else if (oMemWriteEnable && oMemAddress >= BEGINNING_DATA && oMemAddress <= END_DATA) begin
            for (int k = 0; k < 8; k++)
                if (oMemByteEnable[k]) mem_b[idx_of(oMemAddress) + k] <= oMemWriteData[8*k +: 8];
        end
        rd_pipe[0] <= oMemReadEnable ? rd_word(oMemAddress) : 64'd0;
        for (int p = 1; p < LAT; p++) rd_pipe[p] <= rd_pipe[p-1];
    end
    assign iMemReadData = rd_pipe[LAT-1];

    function automatic logic model_fault(logic [63:0] a, int n);
        if (a < BEGINNING_DATA) return 1'b1;
        if ((a % 64'(n)) != 64'd0) return 1'b1;
        if (a > END_DATA - 64'(n - 1)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [63:0] model_load(logic [63:0] a, int n, logic sg);
        logic [63:0] v = 64'd0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = shadow[idx_of(a) + i];
        if (sg && n < 8 && v[8*n-1])
            for (int i = 8*n; i < 64; i++) v[i] = 1'b1;
        return v;
    endfunction

    function automatic logic [7:0] model_be(logic [63:0] a, int n);
        logic [7:0] be = 8'h00;
        for (int i = 0; i < n; i++) be[int'(a[2:0]) + i] = 1'b1;
        return be;
    endfunction

    function automatic logic [63:0] model_wd(logic [63:0] a, int n, logic [63:0] sd);
        logic [63:0] wd = 64'd0;
        for (int i = 0; i < n; i++) wd[8*(int'(a[2:0]) + i) +: 8] = sd[8*i +: 8];
        return wd;
    endfunction

    task automatic model_store(input logic [63:0] a, input int n, input logic [63:0] sd);
        for (int i = 0; i < n; i++) shadow[idx_of(a) + i] = sd[8*i +: 8];
    endtask

    // Starts from a negedge in IDLE; returns at the negedge of the IDLE cycle after completion.
    task automatic run_req(input logic wr, input logic [1:0] sz, input logic sg,
                           input logic [63:0] a, input logic [63:0] sd, output obs_t o);
        iStart = 1'b1; iWrite = wr; iSize = sz; iSigned = sg; iAddress = a; iStoreData = sd;
        o.done_cyc = -1; o.flt = 1'b0; o.ld = 64'd0; o.we_n = 0; o.re_n = 0; o.we_cyc = -1;
        o.be1 = 8'h00; o.wd1 = 64'd0; o.a1 = 64'd0;
        @(posedge iCLK);
        for (int c = 1; c <= 12 && o.done_cyc < 0; c++) begin
            @(negedge iCLK);
            if (c == 1) begin
                iStart = 1'b0;
                o.be1 = oMemByteEnable; o.wd1 = oMemWriteData; o.a1 = oMemAddress;
            end
            if (oMemWriteEnable) begin o.we_n++; o.we_cyc = c; end
            if (oMemReadEnable) o.re_n++;
            if (oDone) begin o.done_cyc = c; o.flt = oFault; o.ld = oLoadData; end
        end
        @(negedge iCLK);
    endtask

    task automatic test_reset();
        iRST_n = 1'b0; init_mem = 1'b1;
        for (int i = 0; i < MEM_BYTES; i++) shadow[i] = init_byte(i);
        repeat (3) @(negedge iCLK);
        init_mem = 1'b0;
        n_cmp++; if (oBusy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", oBusy); end
        n_cmp++; if (oDone !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", oDone); end
        n_cmp++; if (oFault !== 1'b0) begin n_fail++; $display("FAIL reset_fault: got %b want 0", oFault); end
        n_cmp++; if (oLoadData !== 64'd0) begin n_fail++; $display("FAIL reset_load: got %h want 0", oLoadData); end
        n_cmp++; if ({oMemReadEnable, oMemWriteEnable} !== 2'b00) begin n_fail++; $display("FAIL reset_en: got %b want 00", {oMemReadEnable, oMemWriteEnable}); end
        n_cmp++; if (oMemByteEnable !== 8'h00) begin n_fail++; $display("FAIL reset_be: got %h want 00", oMemByteEnable); end
        n_cmp++; if ({oMemAddress, oMemWriteData} !== 128'd0) begin n_fail++; $display("FAIL reset_bus: got %h/%h want 0/0", oMemAddress, oMemWriteData); end
        iRST_n = 1'b1; exp_ld = 64'd0;
        @(negedge iCLK);
    endtask

    task automatic test_sturb();
        obs_t        o;
        logic [63:0] a = BEGINNING_DATA + 64'd5;
        logic [63:0] sd = {$urandom, $urandom};
        sd[7:0] = 8'hAB;
        run_req(1'b1, SZ_BYTE, 1'b0, a, sd, o);
        n_cmp++; if (o.be1 !== 8'h20) begin n_fail++; $display("FAIL sturb_be: got %h want 20", o.be1); end
        n_cmp++; if (o.wd1 !== (64'hAB << 40)) begin n_fail++; $display("FAIL sturb_wd: got %h want %h", o.wd1, 64'hAB << 40); end
        n_cmp++; if (o.we_n !== 1 || o.we_cyc !== 1) begin n_fail++; $display("FAIL sturb_we: got %0d cycles (last %0d) want 1 in cycle 1", o.we_n, o.we_cyc); end
        n_cmp++; if (o.done_cyc !== 2 || o.flt !== 1'b0) begin n_fail++; $display("FAIL sturb_done: got cycle %0d fault %b want 2/0", o.done_cyc, o.flt); end
        model_store(a, 1, sd);
        run_req(1'b0, SZ_BYTE, 1'b1, a, 64'd0, o);
        exp_ld = 64'hFFFF_FFFF_FFFF_FFAB;
        n_cmp++; if (o.ld !== exp_ld) begin n_fail++; $display("FAIL ldursb_readback: got %h want %h", o.ld, exp_ld); end
    endtask

    task automatic test_ldursw();
        obs_t        o;
        logic [63:0] a = BEGINNING_DATA + 64'h104;
        run_req(1'b1, SZ_WORD, 1'b0, a, 64'hDEAD_BEEF_8000_0001, o);
        n_cmp++; if (o.be1 !== 8'hF0 || o.wd1 !== 64'h8000_0001_0000_0000) begin n_fail++; $display("FAIL sturw_lanes: got %h/%h want f0/8000000100000000", o.be1, o.wd1); end
        model_store(a, 4, 64'hDEAD_BEEF_8000_0001);
        run_req(1'b0, SZ_WORD, 1'b1, a, 64'd0, o);
        n_cmp++; if (o.ld !== 64'hFFFF_FFFF_8000_0001) begin n_fail++; $display("FAIL ldursw_signed: got %h want ffffffff80000001", o.ld); end
        n_cmp++; if (o.done_cyc !== 2 + LAT) begin n_fail++; $display("FAIL ldursw_latency: got %0d want %0d", o.done_cyc, 2 + LAT); end
        n_cmp++; if (o.re_n !== 1 + LAT || o.we_n !== 0) begin n_fail++; $display("FAIL ldursw_enables: got re %0d we %0d want %0d/0", o.re_n, o.we_n, 1 + LAT); end
        run_req(1'b0, SZ_WORD, 1'b0, a, 64'd0, o);
        exp_ld = 64'h0000_0000_8000_0001;
        n_cmp++; if (o.ld !== exp_ld) begin n_fail++; $display("FAIL ldurw_unsigned: got %h want %h", o.ld, exp_ld); end
    endtask

    task automatic test_faults();
        obs_t o;
        run_req(1'b0, SZ_DWORD, 1'b0, BEGINNING_DATA + 64'd4, 64'd0, o);
        n_cmp++; if (o.flt !== 1'b1 || o.done_cyc !== 1) begin n_fail++; $display("FAIL ldur_misaligned: got fault %b cycle %0d want 1/1", o.flt, o.done_cyc); end
        n_cmp++; if (o.re_n + o.we_n !== 0 || o.be1 !== 8'h00) begin n_fail++; $display("FAIL fault_enables: got re %0d we %0d be %h want none", o.re_n, o.we_n, o.be1); end
        n_cmp++; if (o.ld !== exp_ld) begin n_fail++; $display("FAIL fault_load_held: got %h want %h", o.ld, exp_ld); end
        run_req(1'b1, SZ_DWORD, 1'b0, END_DATA - 64'd3, 64'h1234, o);
        n_cmp++; if (o.flt !== 1'b1 || o.we_n !== 0) begin n_fail++; $display("FAIL stur_past_end: got fault %b we %0d want 1/0", o.flt, o.we_n); end
        run_req(1'b0, SZ_BYTE, 1'b0, BEGINNING_DATA - 64'd1, 64'd0, o);
        n_cmp++; if (o.flt !== 1'b1) begin n_fail++; $display("FAIL ldurb_below_begin: got fault %b want 1", o.flt); end
        run_req(1'b0, SZ_HALF, 1'b0, END_DATA, 64'd0, o);
        n_cmp++; if (o.flt !== 1'b1) begin n_fail++; $display("FAIL ldurh_at_end: got fault %b want 1", o.flt); end
        run_req(1'b0, SZ_BYTE, 1'b0, END_DATA, 64'd0, o);
        exp_ld = model_load(END_DATA, 1, 1'b0);
        n_cmp++; if (o.flt !== 1'b0 || o.be1 !== 8'h80) begin n_fail++; $display("FAIL ldurb_at_end: got fault %b be %h want 0/80", o.flt, o.be1); end
        n_cmp++; if (o.ld !== exp_ld) begin n_fail++; $display("FAIL ldurb_at_end_data: got %h want %h", o.ld, exp_ld); end
    endtask

    task automatic test_reset_mid();
        obs_t        o;
        int          stray = 0;
        logic [63:0] a = BEGINNING_DATA + 64'h40;
        iStart = 1'b1; iWrite = 1'b0; iSize = SZ_DWORD; iSigned = 1'b0; iAddress = a;
        @(posedge iCLK);
        @(negedge iCLK); iStart = 1'b0;
        @(negedge iCLK);
        n_cmp++; if (oBusy !== 1'b1 || oMemReadEnable !== 1'b1) begin n_fail++; $display("FAIL mid_wait_state: got busy %b re %b want 1/1", oBusy, oMemReadEnable); end
        iRST_n = 1'b0;
        @(negedge iCLK);
        n_cmp++; if (oBusy !== 1'b0 || oDone !== 1'b0 || oLoadData !== 64'd0) begin n_fail++; $display("FAIL mid_reset_abort: got busy %b done %b load %h want 0/0/0", oBusy, oDone, oLoadData); end
        iRST_n = 1'b1; exp_ld = 64'd0;
        repeat (6) begin @(negedge iCLK); if (oDone) stray++; end
        n_cmp++; if (stray !== 0) begin n_fail++; $display("FAIL mid_reset_no_done: got %0d pulses want 0", stray); end
        run_req(1'b0, SZ_DWORD, 1'b0, a, 64'd0, o);
        exp_ld = model_load(a, 8, 1'b0);
        n_cmp++; if (o.ld !== exp_ld || o.done_cyc !== 2 + LAT) begin n_fail++; $display("FAIL mid_reset_recover: got %h cycle %0d want %h cycle %0d", o.ld, o.done_cyc, exp_ld, 2 + LAT); end
    endtask

    task automatic test_random();
        obs_t o;
        for (int it = 0; it < 60; it++) begin
            logic [1:0]  sz = 2'($urandom_range(0, 3));
            int          n = 1 << sz;
            logic        wr = 1'($urandom_range(0, 1));
            logic        sg = 1'($urandom_range(0, 1));
            logic [63:0] a = BEGINNING_DATA - 64'd16 + 64'($urandom_range(0, MEM_BYTES + 31));
            logic [63:0] sd = {$urandom, $urandom};
            logic        f;
            int          exp_cyc;
            if ($urandom_range(0, 3) != 0) a = a - (a % 64'(n));
            f = model_fault(a, n);
            exp_cyc = f ? 1 : (wr ? 2 : 2 + LAT);
            run_req(wr, sz, sg, a, sd, o);
            n_cmp++; if (o.flt !== f || o.done_cyc !== exp_cyc) begin n_fail++; $display("FAIL rnd%0d_status: a=%h sz=%0d wr=%b got fault %b cycle %0d want %b/%0d", it, a, sz, wr, o.flt, o.done_cyc, f, exp_cyc); end
            if (f) begin
                n_cmp++; if (o.re_n + o.we_n !== 0) begin n_fail++; $display("FAIL rnd%0d_fault_en: got re %0d we %0d want 0/0", it, o.re_n, o.we_n); end
            end else begin
                n_cmp++; if (o.be1 !== model_be(a, n) || o.a1 !== {a[63:3], 3'b000}) begin n_fail++; $display("FAIL rnd%0d_bus: got be %h addr %h want %h/%h", it, o.be1, o.a1, model_be(a, n), {a[63:3], 3'b000}); end
            end
            if (!f && wr) begin
                n_cmp++; if (o.wd1 !== model_wd(a, n, sd) || o.we_n !== 1) begin n_fail++; $display("FAIL rnd%0d_store: got wd %h we %0d want %h/1", it, o.wd1, o.we_n, model_wd(a, n, sd)); end
                model_store(a, n, sd);
            end
            if (!f && !wr) exp_ld = model_load(a, n, sg);
            n_cmp++; if (o.ld !== exp_ld) begin n_fail++; $display("FAIL rnd%0d_load: a=%h sz=%0d sg=%b got %h want %h", it, a, sz, sg, o.ld, exp_ld); end
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] a = BEGINNING_DATA + 64'(8 * $urandom_range(0, MEM_BYTES / 8 - 1));
        int          dones = 0;
        iStart = 1'b1; iWrite = 1'b0; iSize = SZ_DWORD; iSigned = 1'b0; iAddress = a;
        exp_ld = model_load(a, 8, 1'b0);
        @(posedge iCLK);
        for (int c = 1; c <= 3 * PER; c++) begin
            @(negedge iCLK);
            if (c == 3 * PER) iStart = 1'b0;
            if (oDone) dones++;
            n_cmp++; if (oDone !== ((c % PER) == 2 + LAT) || oBusy !== ((c % PER) != 0)) begin n_fail++; $display("FAIL b2b_cycle%0d: got done %b busy %b want %b/%b", c, oDone, oBusy, (c % PER) == 2 + LAT, (c % PER) != 0); end
            if (oDone) begin
                n_cmp++; if (oLoadData !== exp_ld) begin n_fail++; $display("FAIL b2b_load: got %h want %h", oLoadData, exp_ld); end
            end
        end
        @(negedge iCLK);
        n_cmp++; if (dones !== 3 || oBusy !== 1'b0) begin n_fail++; $display("FAIL b2b_count: got %0d dones busy %b want 3/0", dones, oBusy); end
    endtask

    task automatic test_lane_align();
        for (int it = 0; it < 24; it++) begin
            logic [1:0]  sz = 2'($urandom_range(0, 3));
            int          n = 1 << sz;
            logic [63:0] off = 64'(n * $urandom_range(0, 8 / n - 1));
            logic [63:0] sd = {$urandom, $urandom};
            logic [63:0] rd = {$urandom, $urandom};
            logic        sg = 1'($urandom_range(0, 1));
            logic [63:0] exp_l = 64'd0;
            lane_tb.size = size_e'(sz); lane_tb.sign = sg; lane_tb.offset = off[2:0];
            lane_tb.store_data = sd; lane_tb.read_data = rd;
            for (int i = 0; i < n; i++) exp_l[8*i +: 8] = rd[8*(int'(off) + i) +: 8];
            if (sg && n < 8 && exp_l[8*n-1]) for (int i = 8*n; i < 64; i++) exp_l[i] = 1'b1;
            #1;
            n_cmp++; if (lane_tb.byte_en !== model_be(off, n) || lane_tb.write_data !== model_wd(off, n, sd)) begin n_fail++; $display("FAIL align%0d_store: got %h/%h want %h/%h", it, lane_tb.byte_en, lane_tb.write_data, model_be(off, n), model_wd(off, n, sd)); end
            n_cmp++; if (lane_tb.load_data !== exp_l) begin n_fail++; $display("FAIL align%0d_load: got %h want %h", it, lane_tb.load_data, exp_l); end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_sturb();
        test_ldursw();
        test_faults();
        test_reset_mid();
        test_random();
        test_back_to_back();
        test_lane_align();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
